// File: rtl/eth_core_pkg.sv
// eth_core_pkg: shared types, status layout and address decode constants
// for the multi-queue Ethernet TX core.
package eth_core_pkg;

   typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} axi_resp_e;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;
   typedef enum logic       {S_IDLE, S_SEND}         sstate_e;

   // Queue select field position in AWADDR/ARADDR
   localparam int QSEL_LSB = 4;
   // Any set address bit at or above this position is an error
   localparam int ERR_LSB  = 8;

   // Status word layout returned on AXI reads
   localparam int ST_WORDS_LSB  = 0;
   localparam int ST_FRAMES_LSB = 16;
   localparam int ST_FULL_BIT   = 24;
   localparam int ST_EMPTY_BIT  = 25;

   function automatic logic [31:0] status_word(input logic [15:0] words,
                                               input logic [7:0]  frames,
                                               input logic        full,
                                               input logic        empty);
      logic [31:0] s;
      s = '0;
      s[ST_WORDS_LSB  +: 16] = words;
      s[ST_FRAMES_LSB +: 8]  = frames;
      s[ST_FULL_BIT]         = full;
      s[ST_EMPTY_BIT]        = empty;
      return s;
   endfunction

endpackage

// File: rtl/eth_q_fifo.sv
// eth_q_fifo: DEPTH x (DATA_W+1) synchronous FIFO. The extra MSB carries the
// end-of-frame tag. Head word is presented combinationally (fall-through).
module eth_q_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W:0]            push_data,
   input  logic                       pop,
   output logic [DATA_W:0]            pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     cnt;
   logic            do_push;
   logic            do_pop;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy tracking; reset flushes the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
         else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
      end
   end

   // Storage array, no reset needed since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/eth_core_mq.sv
// eth_core_mq: AXI4 slave that sorts write bursts into per-queue frame FIFOs,
// reports queue status on reads, and drains complete frames round-robin onto
// a single TX stream.
module eth_core_mq
   import eth_core_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int ID_W       = 4,
   parameter int NUM_Q      = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [ID_W-1:0]           AWID,
   input  logic [ADDR_W-1:0]         AWADDR,
   input  logic [7:0]                AWLEN,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [DATA_W-1:0]         WDATA,
   input  logic                      WLAST,
   input  logic                      WVALID,
   output logic                      WREADY,
   output logic [ID_W-1:0]           BID,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,
   input  logic [ID_W-1:0]           ARID,
   input  logic [ADDR_W-1:0]         ARADDR,
   input  logic [7:0]                ARLEN,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   output logic [ID_W-1:0]           RID,
   output logic [DATA_W-1:0]         RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_last,
   output logic [$clog2(NUM_Q)-1:0]  tx_qid,
   output logic                      tx_valid,
   input  logic                      tx_ready
);

   localparam int QW = $clog2(NUM_Q);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_Q-1:0]  q_push, q_pop, q_full, q_empty;
   logic [NUM_Q-1:0]  frm_inc, frm_dec, eligible;
   logic [DATA_W:0]   q_head   [NUM_Q];
   logic [CW-1:0]     q_count  [NUM_Q];
   logic [7:0]        frame_cnt[NUM_Q];
   logic [DATA_W-1:0] q_status [NUM_Q];

   logic run;
   logic unused_bits;

   wstate_e           wstate, wstate_nx;
   logic [ID_W-1:0]   aw_id;
   logic [QW-1:0]     w_qsel;
   logic              w_err;
   logic              aw_hs, w_hs;

   rstate_e           rstate, rstate_nx;
   logic [ID_W-1:0]   ar_id;
   logic [QW-1:0]     ar_qsel;
   logic              ar_err;
   logic [7:0]        r_left;
   logic [DATA_W-1:0] r_data;
   logic              ar_hs, r_hs;

   sstate_e           sstate, sstate_nx;
   logic [QW-1:0]     sel, rr_ptr, pick, cand;
   logic              pick_vld;
   logic              tx_hs, tx_eof;

   // Burst length is not used: WLAST delimits frames; address bits outside the decode fields are ignored
   assign unused_bits = ^{AWLEN, AWADDR, ARADDR};

   assign aw_hs  = AWVALID && AWREADY;
   assign w_hs   = WVALID && WREADY;
   assign ar_hs  = ARVALID && ARREADY;
   assign r_hs   = RVALID && RREADY;
   assign tx_hs  = tx_valid && tx_ready;
   assign tx_eof = tx_hs && q_head[sel][DATA_W];

   // READY outputs stay low until the first clock after reset release
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) run <= 1'b0;
      else          run <= 1'b1;
   end

   for (genvar q = 0; q < NUM_Q; q++) begin : g_q
      assign q_push[q]   = w_hs && !w_err && (w_qsel == QW'(q));
      assign q_pop[q]    = tx_hs && (sel == QW'(q));
      assign frm_inc[q]  = q_push[q] && WLAST;
      assign frm_dec[q]  = q_pop[q] && q_head[q][DATA_W];
      // A full queue is eligible even mid-frame so oversized frames cut through
      assign eligible[q] = (frame_cnt[q] != 8'd0) || q_full[q];
      assign q_status[q] = DATA_W'(status_word(16'(q_count[q]), frame_cnt[q],
                                               q_full[q], q_empty[q]));

      eth_q_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (ACLK),
         .rst_n     (ARESETn),
         .push      (q_push[q]),
         .push_data ({WLAST, WDATA}),
         .pop       (q_pop[q]),
         .pop_data  (q_head[q]),
         .full      (q_full[q]),
         .empty     (q_empty[q]),
         .count     (q_count[q])
      );
   end

   // Complete-frame counters per queue; simultaneous inc/dec nets to zero
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int q = 0; q < NUM_Q; q++) frame_cnt[q] <= '0;
      end else begin
         for (int q = 0; q < NUM_Q; q++) begin
            if (frm_inc[q] && !frm_dec[q] && frame_cnt[q] != 8'hFF)
               frame_cnt[q] <= frame_cnt[q] + 8'd1;
            else if (frm_dec[q] && !frm_inc[q])
               frame_cnt[q] <= frame_cnt[q] - 8'd1;
         end
      end
   end

   // Write FSM state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) wstate <= W_IDLE;
      else          wstate <= wstate_nx;
   end

   // Write FSM next state
   always_comb begin
      wstate_nx = wstate;
      unique case (wstate)
         W_IDLE:  if (aw_hs)          wstate_nx = W_DATA;
         W_DATA:  if (w_hs && WLAST)  wstate_nx = W_RESP;
         W_RESP:  if (BREADY)         wstate_nx = W_IDLE;
         default:                     wstate_nx = W_IDLE;
      endcase
   end

   // Write FSM outputs; error bursts are always accepted and discarded
   always_comb begin
      AWREADY = run && (wstate == W_IDLE);
      WREADY  = (wstate == W_DATA) && (w_err || !q_full[w_qsel]);
      BVALID  = (wstate == W_RESP);
      BID     = BVALID ? aw_id : '0;
      BRESP   = (BVALID && w_err) ? RESP_SLVERR : RESP_OKAY;
   end

   // Capture the write burst target on the address handshake
   always_ff @(posedge ACLK) begin
      if (aw_hs) begin
         aw_id  <= AWID;
         w_qsel <= AWADDR[QSEL_LSB +: QW];
         w_err  <= |AWADDR[ADDR_W-1:ERR_LSB];
      end
   end

   // Read FSM state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) rstate <= R_IDLE;
      else          rstate <= rstate_nx;
   end

   // Read FSM next state
   always_comb begin
      rstate_nx = rstate;
      unique case (rstate)
         R_IDLE:  if (ar_hs)                  rstate_nx = R_DATA;
         R_DATA:  if (r_hs && r_left == 8'd0) rstate_nx = R_IDLE;
         default:                             rstate_nx = R_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      ARREADY = run && (rstate == R_IDLE);
      RVALID  = (rstate == R_DATA);
      RID     = RVALID ? ar_id : '0;
      RDATA   = RVALID ? r_data : '0;
      RRESP   = (RVALID && ar_err) ? RESP_SLVERR : RESP_OKAY;
      RLAST   = RVALID && (r_left == 8'd0);
   end

   // Status is snapshotted when each beat is issued so RDATA holds under backpressure
   always_ff @(posedge ACLK) begin
      if (ar_hs) begin
         ar_id   <= ARID;
         ar_qsel <= ARADDR[QSEL_LSB +: QW];
         ar_err  <= |ARADDR[ADDR_W-1:ERR_LSB];
         r_left  <= ARLEN;
         r_data  <= (|ARADDR[ADDR_W-1:ERR_LSB]) ? '0 : q_status[ARADDR[QSEL_LSB +: QW]];
      end else if (r_hs && r_left != 8'd0) begin
         r_left  <= r_left - 8'd1;
         r_data  <= ar_err ? '0 : q_status[ar_qsel];
      end
   end

   // Round-robin pick: first eligible queue at or after rr_ptr
   always_comb begin
      pick     = rr_ptr;
      pick_vld = 1'b0;
      cand     = rr_ptr;
      for (int i = NUM_Q - 1; i >= 0; i--) begin
         cand = rr_ptr + QW'(i);
         if (eligible[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Scheduler FSM state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) sstate <= S_IDLE;
      else          sstate <= sstate_nx;
   end

   // Scheduler FSM next state; queue stays locked until its last word leaves
   always_comb begin
      sstate_nx = sstate;
      unique case (sstate)
         S_IDLE:  if (pick_vld) sstate_nx = S_SEND;
         S_SEND:  if (tx_eof)   sstate_nx = S_IDLE;
         default:               sstate_nx = S_IDLE;
      endcase
   end

   // Locked queue and round-robin pointer
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         sel    <= '0;
         rr_ptr <= '0;
      end else begin
         if (sstate == S_IDLE && pick_vld) sel <= pick;
         if (tx_eof) rr_ptr <= sel + QW'(1);
      end
   end

   // TX stream driven straight from the FIFO head, which only moves on a pop
   always_comb begin
      tx_valid = (sstate == S_SEND) && !q_empty[sel];
      tx_data  = tx_valid ? q_head[sel][DATA_W-1:0] : '0;
      tx_last  = tx_valid && q_head[sel][DATA_W];
      tx_qid   = tx_valid ? sel : '0;
   end

endmodule

// File: tb/tb_eth_core_mq.sv
// tb_eth_core_mq: scoreboard bench for eth_core_mq. Written words are queued
// as expected TX beats and retired by a monitor on the TX stream.
module tb_eth_core_mq;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 16;
   localparam int ID_W       = 4;
   localparam int NUM_Q      = 4;
   localparam int FIFO_DEPTH = 16;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [31:0] ST_EMPTY = 32'h0200_0000;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   logic [ID_W-1:0] AWID = '0, BID, ARID = '0, RID;
   logic [ADDR_W-1:0] AWADDR = '0, ARADDR = '0;
   logic [7:0] AWLEN = '0, ARLEN = '0;
   logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
   logic [DATA_W-1:0] WDATA = '0, RDATA, tx_data;
   logic [1:0] BRESP, RRESP;
   logic BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
   logic tx_last, tx_valid, tx_ready = 1'b0;
   logic [1:0] tx_qid;

   typedef struct packed {
      logic [1:0]  qid;
      logic [31:0] data;
      logic        last;
   } txw_t;

   txw_t exp_q[$];
   bit   strict_order = 1'b1;
   bit   rnd_run = 1'b0;
   int   w_beats = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 ACLK = ~ACLK;

   eth_core_mq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
                 .NUM_Q(NUM_Q), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .tx_data(tx_data), .tx_last(tx_last), .tx_qid(tx_qid), .tx_valid(tx_valid),
      .tx_ready(tx_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // TX monitor: retire expected beats, enforce AXIS hold under stall
   bit   prev_stall = 1'b0;
   txw_t prev_word;
   always @(negedge ACLK) begin : mon
      int   idx;
      txw_t e;
      if (!ARESETn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("axis_hold", {tx_valid, tx_qid, tx_data, tx_last}, {1'b1, prev_word});
         if (tx_valid && tx_ready) begin
            idx = -1;
            if (strict_order) begin
               if (exp_q.size() > 0) idx = 0;
            end else begin
               foreach (exp_q[k]) if (idx < 0 && exp_q[k].qid == tx_qid) idx = k;
            end
            if (idx < 0) begin
               chk("tx_unexpected", exp_q.size(), 64'(exp_q.size() + 1));
            end else begin
               e = exp_q[idx];
               exp_q.delete(idx);
               chk("tx_word", {tx_qid, tx_data, tx_last}, {e.qid, e.data, e.last});
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_word  = '{qid: tx_qid, data: tx_data, last: tx_last};
      end
   end

   task automatic axi_write(input string tag, input logic [3:0] id, input logic [15:0] addr,
                            input int nbeats, input logic [31:0] base, input logic [1:0] exp_resp);
      int   t;
      bit   err;
      txw_t e;
      err = (addr[15:8] != 8'h00);
      AWID = id; AWADDR = addr; AWLEN = 8'(nbeats - 1); AWVALID = 1'b1;
      t = 0;
      forever begin
         @(negedge ACLK);
         if (AWREADY) break;
         if (++t > 100) begin chk({tag, "_aw_timeout"}, AWREADY, 1); break; end
      end
      step();
      AWVALID = 1'b0;
      w_beats = 0;
      for (int i = 0; i < nbeats; i++) begin
         WDATA = base + 32'(i); WLAST = (i == nbeats - 1); WVALID = 1'b1;
         t = 0;
         forever begin
            @(negedge ACLK);
            if (WREADY) break;
            if (++t > 400) begin chk({tag, "_w_timeout"}, WREADY, 1); break; end
         end
         if (!err) begin
            e.qid = addr[5:4]; e.data = WDATA; e.last = WLAST;
            exp_q.push_back(e);
         end
         step();
         w_beats++;
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      t = 0;
      forever begin
         @(negedge ACLK);
         if (BVALID) break;
         if (++t > 100) begin chk({tag, "_b_timeout"}, BVALID, 1); break; end
      end
      chk({tag, "_bresp"}, BRESP, exp_resp);
      chk({tag, "_bid"}, BID, id);
      step();
      BREADY = 1'b0;
   endtask

   task automatic axi_read(input string tag, input logic [3:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      int t;
      ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
      t = 0;
      forever begin
         @(negedge ACLK);
         if (ARREADY) break;
         if (++t > 100) begin chk({tag, "_ar_timeout"}, ARREADY, 1); break; end
      end
      step();
      ARVALID = 1'b0; RREADY = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         forever begin
            @(negedge ACLK);
            if (RVALID) break;
            if (++t > 100) begin chk({tag, "_r_timeout"}, RVALID, 1); break; end
         end
         chk({tag, "_rdata"}, RDATA, exp_data);
         chk({tag, "_rresp"}, RRESP, exp_resp);
         chk({tag, "_rid"}, RID, id);
         chk({tag, "_rlast"}, RLAST, (i == int'(len)));
         step();
      end
      RREADY = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || tx_valid) && t < 1000) begin
         step();
         t++;
      end
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset values
      #12;
      chk("rst_awready", AWREADY, 0);
      chk("rst_wready",  WREADY,  0);
      chk("rst_arready", ARREADY, 0);
      chk("rst_bvalid",  {BVALID, BRESP, BID}, 0);
      chk("rst_rvalid",  {RVALID, RRESP, RLAST, RDATA}, 0);
      chk("rst_tx",      {tx_valid, tx_last, tx_qid, tx_data}, 0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      repeat (2) step();
      axi_read("rst_q1_status", 4'h3, 16'h0010, 8'd0, ST_EMPTY, OKAY);

      // 1: single frame to queue 1
      tx_ready = 1'b1;
      axi_write("t1", 4'h1, 16'h0010, 4, 32'd1, OKAY);
      drain("t1");

      // 2: frames to Q0,Q1,Q2 then Q0 again, all held until the sink opens
      tx_ready = 1'b0;
      axi_write("t2_q0a", 4'h2, 16'h0000, 2, 32'h100, OKAY);
      axi_write("t2_q1",  4'h2, 16'h0010, 2, 32'h200, OKAY);
      axi_write("t2_q2",  4'h2, 16'h0020, 2, 32'h300, OKAY);
      axi_write("t2_q0b", 4'h2, 16'h0000, 2, 32'h400, OKAY);
      step();
      tx_ready = 1'b1;
      drain("t2");

      // 3: oversized frame stalls at FIFO full, then cuts through
      tx_ready = 1'b0;
      fork
         axi_write("t3", 4'h3, 16'h0030, 20, 32'h1000, OKAY);
         begin
            int t3;
            t3 = 0;
            while (w_beats < 16 && t3 < 400) begin step(); t3++; end
            repeat (5) step();
            @(negedge ACLK);
            chk("t3_wready_full", WREADY, 0);
            chk("t3_beats_at_full", w_beats, 16);
            step();
            tx_ready = 1'b1;
         end
      join
      drain("t3");

      // 4: error address is swallowed with SLVERR
      axi_write("t4", 4'hA, 16'h0100, 3, 32'h2000, SLVERR);
      repeat (5) step();
      chk("t4_no_tx", tx_valid, 0);
      axi_read("t4_q0_status", 4'h5, 16'h0000, 8'd0, ST_EMPTY, OKAY);
      axi_read("t4_bad_read",  4'h6, 16'h0100, 8'd0, 32'h0, SLVERR);

      // 5: status of a queued 3-word frame
      tx_ready = 1'b0;
      axi_write("t5", 4'h4, 16'h0020, 3, 32'h500, OKAY);
      axi_read("t5_q2_status", 4'h7, 16'h0020, 8'd1, 32'h0001_0003, OKAY);
      tx_ready = 1'b1;
      drain("t5");
      axi_read("t5_q2_after", 4'h8, 16'h0020, 8'd0, ST_EMPTY, OKAY);

      // 6: random sink stalls, then reset in the middle of a frame
      strict_order = 1'b0;
      rnd_run = 1'b1;
      fork
         while (rnd_run) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
         end
      join_none
      axi_write("t6_q1", 4'h1, 16'h0010, 3, 32'h6100, OKAY);
      axi_write("t6_q2", 4'h2, 16'h0020, 5, 32'h6200, OKAY);
      axi_write("t6_q0", 4'h3, 16'h0000, 4, 32'h6000, OKAY);
      axi_write("t6_q3", 4'h4, 16'h0030, 6, 32'h6300, OKAY);
      drain("t6");
      rnd_run = 1'b0;
      repeat (2) step();
      tx_ready = 1'b0;
      axi_write("t6_mid", 4'h5, 16'h0030, 8, 32'h7000, OKAY);
      repeat (2) step();
      tx_ready = 1'b1;
      repeat (3) step();
      tx_ready = 1'b0;
      @(negedge ACLK);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("t6_rst_tx_valid", tx_valid, 0);
      chk("t6_rst_ready", {AWREADY, ARREADY, WREADY}, 0);
      exp_q.delete();
      repeat (3) step();
      @(negedge ACLK);
      ARESETn = 1'b1;
      repeat (2) step();
      tx_ready = 1'b1;
      repeat (5) step();
      chk("t6_no_tx_after_rst", tx_valid, 0);
      for (int q = 0; q < NUM_Q; q++)
         axi_read("t6_status", 4'(q), 16'(q << 4), 8'd0, ST_EMPTY, OKAY);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
